// File: rtl/multiplier_wrapper.sv
// Sequential RV32M multiply unit: 32-iteration shift-add over operand magnitudes,
// followed by a one-cycle sign fix-up and high/low word select, with a go/done handshake.
module multiplier_wrapper (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        go,
  input  logic [1:0]  func3,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        busy,
  output logic        done,
  output logic [31:0] rd
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2
  } state_t;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  state_t      state;
  state_t      stateNext;
  logic [1:0]  func3Q;
  logic [1:0]  func3Next;
  logic [31:0] aMag;
  logic [31:0] aMagNext;
  logic [31:0] bMag;
  logic [31:0] bMagNext;
  logic        neg;
  logic        negNext;
  logic [63:0] acc;
  logic [63:0] accNext;
  logic [4:0]  count;
  logic [4:0]  countNext;
  logic [31:0] rdNext;
  logic        doneNext;

  logic        aSigned;
  logic        bSigned;
  logic        aNeg;
  logic        bNeg;
  logic [31:0] aAbs;
  logic [31:0] bAbs;
  logic [63:0] partial;
  logic [63:0] product;

  // Operand preparation: MUL takes the unsigned path since its low word is sign-agnostic.
  always_comb begin
    aSigned = (func3 == OP_MULH) || (func3 == OP_MULHSU);
    bSigned = (func3 == OP_MULH);
    aNeg    = aSigned & rs1[31];
    bNeg    = bSigned & rs2[31];
    aAbs    = aNeg ? (~rs1 + 32'd1) : rs1;
    bAbs    = bNeg ? (~rs2 + 32'd1) : rs2;
  end

  always_comb begin
    partial = {32'd0, aMag} << count;
    product = neg ? (~acc + 64'd1) : acc;
  end

  assign busy = (state != IDLE);

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state  <= IDLE;
      func3Q <= 2'b00;
      aMag   <= 32'd0;
      bMag   <= 32'd0;
      neg    <= 1'b0;
      acc    <= 64'd0;
      count  <= 5'd0;
      rd     <= 32'd0;
      done   <= 1'b0;
    end else begin
      state  <= stateNext;
      func3Q <= func3Next;
      aMag   <= aMagNext;
      bMag   <= bMagNext;
      neg    <= negNext;
      acc    <= accNext;
      count  <= countNext;
      rd     <= rdNext;
      done   <= doneNext;
    end
  end

  // Next-state and datapath control; a go outside IDLE is simply dropped.
  always_comb begin
    stateNext = state;
    func3Next = func3Q;
    aMagNext  = aMag;
    bMagNext  = bMag;
    negNext   = neg;
    accNext   = acc;
    countNext = count;
    rdNext    = rd;
    doneNext  = 1'b0;

    case (state)
      IDLE: begin
        if (go) begin
          func3Next = func3;
          aMagNext  = aAbs;
          bMagNext  = bAbs;
          negNext   = aNeg ^ bNeg;
          accNext   = 64'd0;
          countNext = 5'd0;
          stateNext = CALC;
        end
      end

      CALC: begin
        if (bMag[0]) begin
          accNext = acc + partial;
        end
        bMagNext  = bMag >> 1;
        countNext = count + 5'd1;
        if (count == 5'd31) begin
          stateNext = SIGN;
        end
      end

      SIGN: begin
        rdNext    = (func3Q == OP_MUL) ? product[31:0] : product[63:32];
        doneNext  = 1'b1;
        stateNext = IDLE;
      end

      default: begin
        stateNext = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_multiplier_wrapper.sv
// Directed self-checking bench for multiplier_wrapper: arithmetic vectors,
// handshake timing, back-to-back issue and mid-operation reset.
module tb_multiplier_wrapper;

  logic        clk;
  logic        clr_n;
  logic        go;
  logic [1:0]  func3;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        busy;
  logic        done;
  logic [31:0] rd;

  int testsRun;
  int testsFailed;

  multiplier_wrapper dut (
    .clk   (clk),
    .clr_n (clr_n),
    .go    (go),
    .func3 (func3),
    .rs1   (rs1),
    .rs2   (rs2),
    .busy  (busy),
    .done  (done),
    .rd    (rd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  localparam int NCASES = 16;
  localparam logic [1:0] F_TAB [NCASES] = '{
    2'b11, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00,
    2'b01, 2'b10, 2'b10, 2'b01, 2'b11, 2'b01, 2'b00, 2'b11
  };
  localparam logic [31:0] A_TAB [NCASES] = '{
    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h80000000,
    32'hFFFFFFFF, 32'h00000007, 32'h00000064, 32'h00000064,
    32'h00000000, 32'h00000002, 32'hFFFFFFFE, 32'h80000000,
    32'h80000000, 32'hFFFFFFFF, 32'h12345678, 32'h12345678
  };
  localparam logic [31:0] B_TAB [NCASES] = '{
    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h80000000,
    32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFF6, 32'hFFFFFFF6,
    32'hFFFFFFFB, 32'h80000000, 32'h80000000, 32'h7FFFFFFF,
    32'h7FFFFFFF, 32'hFFFFFFFF, 32'h00000010, 32'h00000010
  };
  localparam logic [31:0] E_TAB [NCASES] = '{
    32'hFFFFFFFE, 32'h00000001, 32'h40000000, 32'h00000000,
    32'hFFFFFFFF, 32'hFFFFFFEB, 32'hFFFFFFFF, 32'hFFFFFC18,
    32'h00000000, 32'h00000001, 32'hFFFFFFFF, 32'hC0000000,
    32'h3FFFFFFF, 32'h00000000, 32'h23456780, 32'h00000001
  };

  // Issues one operation and waits for done; cycles is 0 if done never arrived.
  task automatic applyStimulus(input logic [1:0] f, input logic [31:0] a,
                               input logic [31:0] b, output logic [31:0] res,
                               output int cycles);
    cycles = 0;
    @(negedge clk);
    func3 = f;
    rs1   = a;
    rs2   = b;
    go    = 1'b1;
    @(posedge clk);
    #1;
    go = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        cycles = i;
        break;
      end
    end
    res = rd;
  endtask

  task automatic test_reset;
    clr_n = 1'b0;
    go    = 1'b0;
    func3 = 2'b00;
    rs1   = 32'd0;
    rs2   = 32'd0;
    #12;
    testsRun++;
    if (busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_busy: got %b expected 0", busy);
    end
    testsRun++;
    if (done !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_done: got %b expected 0", done);
    end
    testsRun++;
    if (rd !== 32'd0) begin
      testsFailed++;
      $display("[TB] FAIL reset_rd: got %h expected 00000000", rd);
    end
    @(negedge clk);
    clr_n = 1'b1;
  endtask

  task automatic test_arith;
    logic [31:0] res;
    int cycles;
    for (int k = 0; k < NCASES; k++) begin
      applyStimulus(F_TAB[k], A_TAB[k], B_TAB[k], res, cycles);
      testsRun++;
      if (cycles != 33) begin
        testsFailed++;
        $display("[TB] FAIL arith_latency[%0d]: got %0d cycles expected 33", k, cycles);
      end
      testsRun++;
      if (res !== E_TAB[k]) begin
        testsFailed++;
        $display("[TB] FAIL arith_rd[%0d]: func3=%b a=%h b=%h got %h expected %h",
                 k, F_TAB[k], A_TAB[k], B_TAB[k], res, E_TAB[k]);
      end
    end
  endtask

  task automatic test_handshake;
    int doneCycle;
    int doneCount;
    doneCycle = 0;
    doneCount = 0;
    @(negedge clk);
    func3 = 2'b00;
    rs1   = 32'd6;
    rs2   = 32'd7;
    go    = 1'b1;
    @(posedge clk);
    #1;
    testsRun++;
    if (busy !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL hs_busy_e0: got %b expected 1", busy);
    end
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 5) begin
        go    = 1'b1;
        func3 = 2'b11;
        rs1   = 32'd11;
        rs2   = 32'd13;
      end else begin
        go = 1'b0;
      end
      @(posedge clk);
      #1;
      if (done) begin
        doneCount++;
        if (doneCycle == 0) doneCycle = i;
      end
      if (i == 32) begin
        testsRun++;
        if (busy !== 1'b1) begin
          testsFailed++;
          $display("[TB] FAIL hs_busy_e32: got %b expected 1", busy);
        end
      end
      if (i == 33) begin
        testsRun++;
        if (busy !== 1'b0) begin
          testsFailed++;
          $display("[TB] FAIL hs_busy_e33: got %b expected 0", busy);
        end
        testsRun++;
        if (rd !== 32'h0000002A) begin
          testsFailed++;
          $display("[TB] FAIL hs_rd: got %h expected 0000002a", rd);
        end
      end
    end
    testsRun++;
    if (doneCycle != 33) begin
      testsFailed++;
      $display("[TB] FAIL hs_done_cycle: got %0d expected 33", doneCycle);
    end
    testsRun++;
    if (doneCount != 1) begin
      testsFailed++;
      $display("[TB] FAIL hs_done_count: got %0d expected 1", doneCount);
    end
  endtask

  task automatic test_back_to_back;
    int firstDone;
    int secondDone;
    firstDone  = 0;
    secondDone = 0;
    @(negedge clk);
    func3 = 2'b00;
    rs1   = 32'h00000064;
    rs2   = 32'hFFFFFFF6;
    go    = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      if (i == 34) begin
        go    = 1'b1;
        func3 = 2'b11;
        rs1   = 32'hFFFFFFFF;
        rs2   = 32'hFFFFFFFF;
      end else begin
        go = 1'b0;
      end
      @(posedge clk);
      #1;
      if (done) begin
        if (firstDone == 0) firstDone = i;
        else if (secondDone == 0) secondDone = i;
      end
      if (i == 50) begin
        testsRun++;
        if (rd !== 32'hFFFFFC18) begin
          testsFailed++;
          $display("[TB] FAIL b2b_rd_hold: got %h expected fffffc18", rd);
        end
      end
      if (i == 67) begin
        testsRun++;
        if (rd !== 32'hFFFFFFFE) begin
          testsFailed++;
          $display("[TB] FAIL b2b_rd_second: got %h expected fffffffe", rd);
        end
      end
    end
    testsRun++;
    if (firstDone != 33) begin
      testsFailed++;
      $display("[TB] FAIL b2b_first_done: got %0d expected 33", firstDone);
    end
    testsRun++;
    if (secondDone != 67) begin
      testsFailed++;
      $display("[TB] FAIL b2b_second_done: got %0d expected 67", secondDone);
    end
  endtask

  task automatic test_reset_mid;
    int doneCount;
    int cycles;
    logic [31:0] res;
    doneCount = 0;
    @(negedge clk);
    func3 = 2'b00;
    rs1   = 32'd3;
    rs2   = 32'd5;
    go    = 1'b1;
    @(posedge clk);
    #1;
    go = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    #2;
    clr_n = 1'b0;
    #1;
    testsRun++;
    if (busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL midrst_busy: got %b expected 0", busy);
    end
    testsRun++;
    if (done !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL midrst_done: got %b expected 0", done);
    end
    testsRun++;
    if (rd !== 32'd0) begin
      testsFailed++;
      $display("[TB] FAIL midrst_rd: got %h expected 00000000", rd);
    end
    @(negedge clk);
    clr_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) doneCount++;
    end
    testsRun++;
    if (doneCount != 0) begin
      testsFailed++;
      $display("[TB] FAIL midrst_no_done: got %0d pulses expected 0", doneCount);
    end
    applyStimulus(2'b00, 32'd6, 32'd7, res, cycles);
    testsRun++;
    if (cycles != 33) begin
      testsFailed++;
      $display("[TB] FAIL midrst_latency: got %0d cycles expected 33", cycles);
    end
    testsRun++;
    if (res !== 32'h0000002A) begin
      testsFailed++;
      $display("[TB] FAIL midrst_rd_after: got %h expected 0000002a", res);
    end
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    test_reset();
    test_arith();
    test_handshake();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
